// File: rtl/piso_tx_pkg.sv
// Shared types and sizing helpers for the PISO transmit controller.
// Also holds the even-parity helper used when PISO_TX_CTRL_PARITY_EN is defined.
package piso_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } tx_state_e;

   localparam int DEF_WIDTH     = 32'sd4;
   localparam int DEF_GAP       = 32'sd1;
   localparam int DEF_MSB_FIRST = 32'sd1;

   // Counter width for a counter that must hold values 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 32'sd2) ? 32'sd1 : $clog2(n);
   endfunction

   function automatic logic even_parity(input logic [63:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit parallel-load shift register with zero fill; head is the next bit on the line.
// Shift direction follows MSB_FIRST.
module piso_shift_reg #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] load_data,
   output logic             head
);

   logic [WIDTH-1:0] sreg_r;

   // Load has priority over shift; zeros fill in behind the departing bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg_r <= {WIDTH{1'b0}};
      end else if (load) begin
         sreg_r <= load_data;
      end else if (shift_en) begin
         if (MSB_FIRST) begin
            sreg_r <= {sreg_r[WIDTH-2:0], 1'b0};
         end else begin
            sreg_r <= {1'b0, sreg_r[WIDTH-1:1]};
         end
      end else begin
         sreg_r <= sreg_r;
      end
   end

   assign head = MSB_FIRST ? sreg_r[WIDTH-1] : sreg_r[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Valid/ready parallel-in, serial-out transmitter: frames each word with strobe, last-bit and gap.
// Define PISO_TX_CTRL_PARITY_EN to append an even-parity bit to every frame.
module piso_tx_ctrl
   import piso_tx_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int GAP       = DEF_GAP,
   parameter int MSB_FIRST = DEF_MSB_FIRST
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             last_bit,
   output logic             busy
);

`ifdef PISO_TX_CTRL_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 32'sd1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CNT_W = cnt_w(WIDTH + 32'sd1);
   localparam int GAP_W = cnt_w(GAP + 32'sd1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 32'sd1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 32'sd0) ? (GAP - 32'sd1) : 32'sd0);

   tx_state_e        state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [GAP_W-1:0] gap_r, gap_s;
   logic             load_s, shift_s, head_s;
   logic             in_ready_r, busy_r, serial_valid_r, last_bit_r;

   piso_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST != 32'sd0)
   ) u_shift_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (load_s),
      .shift_en  (shift_s),
      .load_data (in_data),
      .head      (head_s)
   );

   // Next-state, counter and shift-register control decode.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      gap_s   = gap_r;
      load_s  = 1'b0;
      shift_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (in_valid && in_ready_r) begin
               state_s = ST_SHIFT;
               cnt_s   = CNT_LOAD;
               load_s  = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            shift_s = 1'b1;
            if (cnt_r == {CNT_W{1'b0}}) begin
               if (GAP > 32'sd0) begin
                  state_s = ST_GAP;
                  gap_s   = GAP_LOAD;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         ST_GAP: begin
            if (gap_r == {GAP_W{1'b0}}) begin
               state_s = ST_IDLE;
            end else begin
               gap_s = gap_r - {{(GAP_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = {CNT_W{1'b0}};
            gap_s   = {GAP_W{1'b0}};
         end
      endcase
   end

   // State, counters and status outputs; outputs are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         cnt_r          <= {CNT_W{1'b0}};
         gap_r          <= {GAP_W{1'b0}};
         in_ready_r     <= 1'b1;
         busy_r         <= 1'b0;
         serial_valid_r <= 1'b0;
         last_bit_r     <= 1'b0;
      end else begin
         state_r        <= state_s;
         cnt_r          <= cnt_s;
         gap_r          <= gap_s;
         in_ready_r     <= (state_s == ST_IDLE);
         busy_r         <= (state_s != ST_IDLE);
         serial_valid_r <= (state_s == ST_SHIFT);
         last_bit_r     <= (state_s == ST_SHIFT) && (cnt_s == {CNT_W{1'b0}});
      end
   end

`ifdef PISO_TX_CTRL_PARITY_EN
   logic parity_r;

   // Parity of the word captured at acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_r <= 1'b0;
      end else if (load_s) begin
         parity_r <= even_parity(64'(in_data));
      end else begin
         parity_r <= parity_r;
      end
   end

   // The shift register has emptied to zeros by the parity slot, so OR-ing is safe.
   assign serial_out = head_s | (last_bit_r & parity_r);
`else
   assign serial_out = head_s;
`endif

   assign in_ready     = in_ready_r;
   assign busy         = busy_r;
   assign serial_valid = serial_valid_r;
   assign last_bit     = last_bit_r;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl: three instances (MSB/GAP=1, MSB/GAP=0, LSB/GAP=1) share stimulus.
// Expectations adapt to PISO_TX_CTRL_PARITY_EN when it is defined.
module tb_piso_tx_ctrl;

`ifdef PISO_TX_CTRL_PARITY_EN
   localparam int FL = 5;
   localparam logic [4:0] W1011_M = 5'b10111;
   localparam logic [4:0] W1011_L = 5'b11011;
   localparam logic [4:0] WA_M    = 5'b10100;
   localparam logic [4:0] W5_M    = 5'b01010;
   localparam logic [4:0] W3_M    = 5'b00110;
   localparam logic [4:0] W3_L    = 5'b11000;
`else
   localparam int FL = 4;
   localparam logic [4:0] W1011_M = 5'b01011;
   localparam logic [4:0] W1011_L = 5'b01101;
   localparam logic [4:0] WA_M    = 5'b01010;
   localparam logic [4:0] W5_M    = 5'b00101;
   localparam logic [4:0] W3_M    = 5'b00011;
   localparam logic [4:0] W3_L    = 5'b01100;
`endif
   // Observation vector layout: {serial_out, serial_valid, last_bit, busy, in_ready}
   localparam logic [4:0] O_IDLE = 5'b00001;
   localparam logic [4:0] O_GAP  = 5'b00010;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] in_data = 4'h0;
   logic       in_valid = 1'b0;
   logic       rdy_a, so_a, sv_a, lb_a, bz_a;
   logic       rdy_b, so_b, sv_b, lb_b, bz_b;
   logic       rdy_c, so_c, sv_c, lb_c, bz_c;
   int         pass_cnt = 0;
   int         fail_cnt = 0;
   int         total_cnt = 0;

   always #5 clk = ~clk;

   piso_tx_ctrl #(.WIDTH(4), .GAP(1), .MSB_FIRST(1)) dut_a (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
      .serial_out(so_a), .serial_valid(sv_a), .last_bit(lb_a), .busy(bz_a));
   piso_tx_ctrl #(.WIDTH(4), .GAP(0), .MSB_FIRST(1)) dut_b (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
      .serial_out(so_b), .serial_valid(sv_b), .last_bit(lb_b), .busy(bz_b));
   piso_tx_ctrl #(.WIDTH(4), .GAP(1), .MSB_FIRST(0)) dut_c (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_c),
      .serial_out(so_c), .serial_valid(sv_c), .last_bit(lb_c), .busy(bz_c));

   wire [4:0] obs_a = {so_a, sv_a, lb_a, bz_a, rdy_a};
   wire [4:0] obs_b = {so_b, sv_b, lb_b, bz_b, rdy_b};
   wire [4:0] obs_c = {so_c, sv_c, lb_c, bz_c, rdy_c};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [4:0] observed, input logic [4:0] expected);
      total_cnt = total_cnt + 1;
      assert (observed === expected) pass_cnt = pass_cnt + 1;
      else begin
         fail_cnt = fail_cnt + 1;
         $error("FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   // Walks one frame from its first bit to its last, checking the selected instances each cycle.
   task automatic frame_chk(input string tag, input logic [2:0] mask, input logic [4:0] ba,
                            input logic [4:0] bb, input logic [4:0] bc, input int n);
      logic lb;
      for (int i = 0; i < n; i++) begin
         lb = (i == n - 1);
         if (mask[0]) chk($sformatf("%s_a%0d", tag, i), obs_a, {ba[n-1-i], 1'b1, lb, 1'b1, 1'b0});
         if (mask[1]) chk($sformatf("%s_b%0d", tag, i), obs_b, {bb[n-1-i], 1'b1, lb, 1'b1, 1'b0});
         if (mask[2]) chk($sformatf("%s_c%0d", tag, i), obs_c, {bc[n-1-i], 1'b1, lb, 1'b1, 1'b0});
         if (i < n - 1) tick();
      end
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("reset_a", obs_a, O_IDLE);
      chk("reset_b", obs_b, O_IDLE);
      chk("reset_c", obs_c, O_IDLE);
      rst = 1'b0;
      tick();

      // Single word 1011: MSB-first on a/b, LSB-first on c
      in_data  = 4'b1011;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = 4'b0000;
      frame_chk("w1011", 3'b111, W1011_M, W1011_M, W1011_L, FL);
      tick();
      chk("w1011_gap_a", obs_a, O_GAP);
      chk("w1011_gap_c", obs_c, O_GAP);
      chk("w1011_nogap_b", obs_b, O_IDLE);
      tick();
      chk("w1011_idle_a", obs_a, O_IDLE);
      chk("w1011_idle_c", obs_c, O_IDLE);

      // Back-to-back on b (GAP=0) with in_valid held; in_data changes mid-frame
      in_data  = 4'hA;
      in_valid = 1'b1;
      tick();
      in_data  = 4'h5;
      frame_chk("b2b_1", 3'b010, 5'b00000, WA_M, 5'b00000, FL);
      tick();
      chk("b2b_ready_b", obs_b, O_IDLE);
      chk("gap_holds_a", obs_a, O_GAP);
      tick();
      in_valid = 1'b0;
      chk("gap_done_a", obs_a, O_IDLE);
      frame_chk("b2b_2", 3'b010, 5'b00000, W5_M, 5'b00000, FL);
      tick();
      chk("b2b_end_b", obs_b, O_IDLE);
      for (int k = 0; k < 4; k++) tick();
      chk("settle_a", obs_a, O_IDLE);
      chk("settle_c", obs_c, O_IDLE);

      // Reset after the second bit of 4'hF
      in_data  = 4'hF;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("mf_bit1_a", obs_a, 5'b11010);
      tick();
      chk("mf_bit2_a", obs_a, 5'b11010);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mf_rst_a", obs_a, O_IDLE);
      chk("mf_rst_c", obs_c, O_IDLE);
      tick();
      chk("mf_nolast_a", obs_a, O_IDLE);
      in_data  = 4'h3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      frame_chk("w0011", 3'b101, W3_M, 5'b00000, W3_L, FL);
      for (int k = 0; k < 3; k++) tick();
      chk("w0011_idle_a", obs_a, O_IDLE);

      // rst and in_valid together: word must not be accepted
      in_data  = 4'hF;
      in_valid = 1'b1;
      rst      = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("coinc_a", obs_a, O_IDLE);
      tick();
      chk("coinc_idle_a", obs_a, O_IDLE);
      chk("coinc_idle_b", obs_b, O_IDLE);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
